// File: rtl/adc_frame_source_if.sv
// adc_frame_source_if: frame-stream bundle between the ADC frame source
// (master) and the FFT input stage (slave). The master drives the replayed
// sample, its index and the valid/last qualifiers. The slave returns a
// level-sensitive ready that means "a whole frame can be accepted".
interface adc_frame_source_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11
);
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              adc_valid;
    logic              adc_last;
    logic              fft_ready;

    modport master (
        output data,
        output addr,
        output adc_valid,
        output adc_last,
        input  fft_ready
    );

    modport slave (
        input  data,
        input  addr,
        input  adc_valid,
        input  adc_last,
        output fft_ready
    );
endinterface

// File: rtl/adc_frame_source.sv
// adc_frame_source: captures one frame of N = 2^ADDR_W raw ADC codes,
// keeping every DECIM-th strobed sample. It then replays the frame as a
// gap-free burst toward the FFT path once the consumer reports ready.
//
// Optional feature macro: ADC_FRAME_CONT_EN
//   defined   - after a burst the block re-enters capture on its own. Frames
//               repeat until rst, and only the first frame needs an arm pulse.
//   undefined - single shot: one frame per arm pulse, then back to idle.
module adc_frame_source #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11,
    parameter int DECIM  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_din,
    input  logic              adc_strobe,
    input  logic              arm,
    output logic              busy,
    output logic              overrun,
    adc_frame_source_if.master fft
);
    localparam int                N         = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [7:0]        DEC_LAST  = 8'(DECIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PLAY    = 2'd3
    } state_t;

`ifdef ADC_FRAME_CONT_EN
    // Continuous mode: the end of a burst starts the next capture directly.
    localparam state_t PLAY_EXIT = ST_CAPTURE;
`else
    // Single-shot mode: the end of a burst returns to idle and waits for arm.
    localparam state_t PLAY_EXIT = ST_IDLE;
`endif

    state_t state_reg;
    state_t state_next;

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [7:0]        dec_cnt_reg;
    logic [7:0]        dec_cnt_next;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_next;

    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;
    logic              valid_reg;
    logic              valid_next;
    logic              last_reg;
    logic              last_next;
    logic              busy_reg;
    logic              busy_next;
    logic              overrun_reg;
    logic              overrun_next;

    logic [DATA_W-1:0] ram [N];

    logic arm_ok;
    logic arm_err;
    logic keep;
    logic wr_done;
    logic rd_en;
    logic rd_done;

    // busy_reg stays high through the adc_last cycle, even though the FSM is
    // already back in IDLE then. So an arm in that cycle is rejected as an
    // overrun rather than starting a new capture.
    assign arm_ok  = arm & ~busy_reg;
    assign arm_err = arm &  busy_reg;

    // A strobe is written only in CAPTURE, and only on decimation phase 0.
    assign keep    = (state_reg == ST_CAPTURE) & adc_strobe & (dec_cnt_reg == 8'd0);
    assign wr_done = keep & (wr_ptr_reg == LAST_ADDR);

    // Each PLAY cycle issues one RAM read; the final one is address N-1.
    assign rd_en   = (state_reg == ST_PLAY);
    assign rd_done = rd_en & (rd_ptr_reg == LAST_ADDR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Once PLAY starts, fft_ready is not looked at again.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (arm_ok)        state_next = ST_CAPTURE;
            ST_CAPTURE: if (wr_done)       state_next = ST_WAIT;
            ST_WAIT:    if (fft.fft_ready) state_next = ST_PLAY;
            ST_PLAY:    if (rd_done)       state_next = PLAY_EXIT;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values for the pointers and the registered outputs.
    // The pointers are held at zero outside their active state, so every
    // capture and every burst starts from index 0.
    always_comb begin
        wr_ptr_next  = '0;
        dec_cnt_next = '0;
        rd_ptr_next  = '0;
        if (state_reg == ST_CAPTURE) begin
            wr_ptr_next  = wr_ptr_reg;
            dec_cnt_next = dec_cnt_reg;
            if (adc_strobe) begin
                dec_cnt_next = (dec_cnt_reg == DEC_LAST) ? 8'd0 : dec_cnt_reg + 8'd1;
            end
            if (keep) begin
                wr_ptr_next = wr_done ? '0 : wr_ptr_reg + ADDR_W'(1);
            end
        end
        if (rd_en) begin
            rd_ptr_next = rd_done ? '0 : rd_ptr_reg + ADDR_W'(1);
        end

        valid_next   = rd_en;
        addr_next    = rd_en ? rd_ptr_reg : '0;
        last_next    = rd_done;
        busy_next    = (state_next != ST_IDLE) | rd_en;
        overrun_next = overrun_reg | arm_err;
    end

    // Pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            dec_cnt_reg <= '0;
            rd_ptr_reg  <= '0;
            addr_reg    <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            dec_cnt_reg <= dec_cnt_next;
            rd_ptr_reg  <= rd_ptr_next;
            addr_reg    <= addr_next;
            valid_reg   <= valid_next;
            last_reg    <= last_next;
            busy_reg    <= busy_next;
            overrun_reg <= overrun_next;
        end
    end

    // Frame buffer write port. The contents need no reset.
    always_ff @(posedge clk) begin
        if (keep) begin
            ram[wr_ptr_reg] <= adc_din;
        end
    end

    // Frame buffer read port. The registered read is the data output, and it
    // is cleared whenever no read is issued, so data is 0 while adc_valid is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
        end else if (rd_en) begin
            data_reg <= ram[rd_ptr_reg];
        end else begin
            data_reg <= '0;
        end
    end

    assign fft.data      = data_reg;
    assign fft.addr      = addr_reg;
    assign fft.adc_valid = valid_reg;
    assign fft.adc_last  = last_reg;
    assign busy          = busy_reg;
    assign overrun       = overrun_reg;
endmodule

// File: tb/tb_adc_frame_source.sv
// tb_adc_frame_source: randomized frame-level bench for adc_frame_source.
// Two instances, DECIM=1 and DECIM=4, share every input except arm. The bench
// selects one instance at a time and resets both between selections.
// For each frame a reference queue records every DECIM-th strobed value
// after the arm cycle. The burst must reproduce that queue at the timing
// the block's rules dictate.
module tb_adc_frame_source;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 11;
    localparam int N      = 1 << ADDR_W;
`ifdef ADC_FRAME_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] adc_din = '0;
    logic              adc_strobe = 1'b0;
    logic              arm = 1'b0;
    logic              fft_ready = 1'b0;
    logic              sel4 = 1'b0;

    logic arm_a, arm_b, busy_a, busy_b, ovr_a, ovr_b;

    adc_frame_source_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a ();
    adc_frame_source_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();

    assign if_a.fft_ready = fft_ready;
    assign if_b.fft_ready = fft_ready;
    assign arm_a = arm & ~sel4;
    assign arm_b = arm &  sel4;

    adc_frame_source #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DECIM(1)) dut_a (
        .clk(clk), .rst(rst), .adc_din(adc_din), .adc_strobe(adc_strobe),
        .arm(arm_a), .busy(busy_a), .overrun(ovr_a), .fft(if_a)
    );

    adc_frame_source #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DECIM(4)) dut_b (
        .clk(clk), .rst(rst), .adc_din(adc_din), .adc_strobe(adc_strobe),
        .arm(arm_b), .busy(busy_b), .overrun(ovr_b), .fft(if_b)
    );

    logic [DATA_W-1:0] o_data;
    logic [ADDR_W-1:0] o_addr;
    logic              o_valid, o_last, o_busy, o_ovr;

    assign o_data  = sel4 ? if_b.data      : if_a.data;
    assign o_addr  = sel4 ? if_b.addr      : if_a.addr;
    assign o_valid = sel4 ? if_b.adc_valid : if_a.adc_valid;
    assign o_last  = sel4 ? if_b.adc_last  : if_a.adc_last;
    assign o_busy  = sel4 ? busy_b         : busy_a;
    assign o_ovr   = sel4 ? ovr_b          : ovr_a;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycles = 0;
    int decim  = 1;
    bit exp_ovr = 1'b0;
    bit arm_next = 1'b0;

    // Count one comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycles);
        end
    endtask

    // Advance one clock. Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cycles++;
        if (cycles > 90000) begin
            errors++;
            $display("FAIL cycle_budget: got %0d cycles expected under 90000", cycles);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic rand_strobe(input int pct);
        adc_strobe = ($urandom_range(0, 99) < pct);
        adc_din    = DATA_W'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},    32'(o_data),  0);
        check({tag, "_addr"},    32'(o_addr),  0);
        check({tag, "_valid"},   32'(o_valid), 0);
        check({tag, "_last"},    32'(o_last),  0);
        check({tag, "_busy"},    32'(o_busy),  0);
        check({tag, "_overrun"}, 32'(o_ovr),   0);
    endtask

    // One frame: optional arm, capture, wait, burst, then the post-burst tail.
    task automatic run_frame(input bit do_arm, input bit ready_early, input bit arm_mid,
                             input bit arm_last, input int abort_at, input int wait_cycles);
        logic [DATA_W-1:0] kept[$];
        int scnt;
        int bad;
        bit mid_done;
        scnt = 0;
        mid_done = 1'b0;
        if (do_arm) begin
            arm = 1'b1;
            adc_strobe = 1'b1;          // coincident strobe must not be captured
            adc_din = DATA_W'($urandom);
            fft_ready = ready_early;
            step();
            arm = 1'b0;
            check("arm_busy", 32'(o_busy), 1);
        end
        fft_ready = ready_early;
        bad = 0;
        while (kept.size() < N) begin
            rand_strobe(85);
            arm = arm_next;
            if (arm_next) exp_ovr = 1'b1;
            if (arm_mid && !mid_done && kept.size() == N / 3) begin
                arm = 1'b1;
                exp_ovr = 1'b1;
                mid_done = 1'b1;
            end
            if (adc_strobe) begin
                if (scnt % decim == 0) kept.push_back(adc_din);
                scnt++;
            end
            step();
            arm_next = 1'b0;
            if (o_valid !== 1'b0 || o_busy !== 1'b1) bad++;
        end
        arm = 1'b0;
        check("capture_quiet_err", 32'(bad), 0);
        check("overrun_after_capture", 32'(o_ovr), 32'(exp_ovr));

        bad = 0;
        if (!ready_early) begin
            for (int w = 0; w < wait_cycles; w++) begin
                rand_strobe(50);
                step();
                if (o_valid !== 1'b0 || o_busy !== 1'b1) bad++;
            end
            check("wait_hold_err", 32'(bad), 0);
            fft_ready = 1'b1;
        end
        rand_strobe(50);
        step();                          // fft_ready sampled: first PLAY cycle
        check("play_first_cycle_valid", 32'(o_valid), 0);

        bad = 0;
        for (int i = 0; i < N; i++) begin
            rand_strobe(50);
            fft_ready = 1'($urandom_range(0, 1));
            step();
            if (o_valid !== 1'b1 || o_addr !== ADDR_W'(i) || o_data !== kept[i] ||
                o_last !== (i == N - 1)) bad++;
            if (i == 0) begin
                check("first_valid", 32'(o_valid), 1);
                check("first_addr",  32'(o_addr),  0);
                check("first_data",  32'(o_data),  32'(kept[0]));
            end
            if (i == abort_at) begin
                check("abort_addr", 32'(o_addr), 32'(abort_at));
                rst = 1'b1;
                step();
                rst = 1'b0;
                exp_ovr = 1'b0;
                arm_next = 1'b0;
                check_all_zero("abort");
                check("abort_burst_err", 32'(bad), 0);
                return;
            end
        end
        fft_ready = 1'b0;
        check("burst_err",    32'(bad),     0);
        check("last_addr",    32'(o_addr),  N - 1);
        check("last_flag",    32'(o_last),  1);
        check("last_data",    32'(o_data),  32'(kept[N - 1]));
        check("busy_on_last", 32'(o_busy),  1);

        if (CONT) begin
            arm_next = arm_last;         // lands in the adc_last cycle
        end else begin
            arm = arm_last;
            if (arm_last) exp_ovr = 1'b1;
            rand_strobe(50);
            step();
            arm = 1'b0;
            check("busy_after_last",  32'(o_busy),  0);
            check("valid_after_last", 32'(o_valid), 0);
            check("overrun_tail",     32'(o_ovr),   32'(exp_ovr));
            bad = 0;
            for (int t = 0; t < 4; t++) begin
                rand_strobe(50);
                step();
                if (o_busy !== 1'b0 || o_valid !== 1'b0) bad++;
            end
            check("idle_after_frame_err", 32'(bad), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check("idle_busy", 32'(o_busy), 0);

        // DECIM = 1 instance
        sel4 = 1'b0;
        decim = 1;
        run_frame(1'b1,  1'b1, 1'b0, 1'b0, -1,   0);
        run_frame(!CONT, 1'b0, 1'b1, 1'b0, -1,   100);
        run_frame(!CONT, 1'b0, 1'b0, 1'b1, -1,   $urandom_range(1, 20));
        run_frame(!CONT, 1'b1, 1'b0, 1'b0, 1000, 0);
        run_frame(1'b1,  1'b0, 1'b0, 1'b0, -1,   $urandom_range(1, 10));

        // DECIM = 4 instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ovr = 1'b0;
        arm_next = 1'b0;
        sel4 = 1'b1;
        decim = 4;
        step();
        check_all_zero("switch");
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
